// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers; divider built only when MD_UNIT_DIV_EN is defined.
// Latency: MULT/MULTU take MULT_CYCLES, DIV/DIVU take DIV_CYCLES; MTHI/MTLO write in one edge.
// Backpressure: busy is high while an operation runs; start during busy is dropped, never queued.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Low 64 bits of the product of sign-extended operands equal the signed 32x32 product.
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

`ifdef MD_UNIT_DIV_EN
  logic        div_sgn;
  logic [31:0] a_mag, b_mag, uq, ur, div_q, div_r;
  assign div_sgn = ~op_q[0];
  assign a_mag   = (div_sgn && a_q[31]) ? (~a_q + 32'd1) : a_q;
  assign b_mag   = (div_sgn && b_q[31]) ? (~b_q + 32'd1) : b_q;
  assign uq      = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
  assign ur      = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign div_q   = (div_sgn && (a_q[31] ^ b_q[31])) ? (~uq + 32'd1) : uq;
  assign div_r   = (div_sgn && a_q[31]) ? (~ur + 32'd1) : ur;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              op_d    = op;
              a_d     = a;
              b_d     = b;
              cnt_d   = 4'(MULT_CYCLES);
              state_d = RUN;
            end
`ifdef MD_UNIT_DIV_EN
            OP_DIV, OP_DIVU: begin
              op_d    = op;
              a_d     = a;
              b_d     = b;
              cnt_d   = 4'(DIV_CYCLES);
              state_d = RUN;
            end
`endif
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
`ifdef MD_UNIT_DIV_EN
            OP_DIV, OP_DIVU: begin
              // Divide by zero burns the full latency but leaves HI/LO untouched.
              if (b_q != 32'd0) begin
                hi_d = div_r;
                lo_d = div_q;
              end
            end
`endif
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: multiply, divide (or its absence), MTHI/MTLO, drop-while-busy, reset abort.
module tb_md_unit;
  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives start for exactly one posedge; returns at the negedge after acceptance.
  task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = va;
    b     = vb;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called right after issue(): busy must be high for n cycles, then drop with results visible.
  task automatic run_check(input int n, input logic [31:0] eh, input logic [31:0] el, input string tag);
    chk({tag, "_busy_first"}, {31'd0, busy}, 32'd1);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Signed multiply: -2 * 3.
    issue(3'b000, 32'hFFFFFFFE, 32'd3);
    run_check(5, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg");

    // Unsigned multiply with operands scrambled mid-run.
    issue(3'b001, 32'hFFFFFFFF, 32'd2);
    a = 32'h00000055;
    b = 32'h00000077;
    run_check(5, 32'h00000001, 32'hFFFFFFFE, "multu");

    // MTHI arriving while a MULT runs is dropped.
    issue(3'b000, 32'd5, 32'd7);
    @(negedge clk);
    start = 1'b1;
    op    = 3'b100;
    a     = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    chk("mthi_busy_still", {31'd0, busy}, 32'd1);
    chk("mthi_busy_hi_hold", hi, 32'h00000001);
    wait_idle(10, "mthi_busy");
    chk("mthi_busy_hi", hi, 32'h00000000);
    chk("mthi_busy_lo", lo, 32'h00000023);

    // Direct moves write in one edge without busy.
    issue(3'b100, 32'h12345678, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'h12345678);
    issue(3'b101, 32'h12345678, 32'd0);
    chk("mtlo_lo", lo, 32'h12345678);
    chk("mtlo_hi_hold", hi, 32'h12345678);

    // Reserved op is a no-op.
    issue(3'b110, 32'hCAFEF00D, 32'd9);
    chk("rsvd_busy", {31'd0, busy}, 32'd0);
    chk("rsvd_hi", hi, 32'h12345678);
    chk("rsvd_lo", lo, 32'h12345678);

`ifdef MD_UNIT_DIV_EN
    // Divide by zero keeps the preloaded HI/LO after the full latency.
    issue(3'b011, 32'd7, 32'd0);
    run_check(10, 32'h12345678, 32'h12345678, "divu_zero");
    issue(3'b010, 32'hFFFFFFF9, 32'd2);
    run_check(10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    run_check(10, 32'h00000000, 32'h80000000, "div_ovf");
    issue(3'b011, 32'd100, 32'd7);
    run_check(10, 32'h00000002, 32'h0000000E, "divu");
`else
    // Without the divider, DIV/DIVU never raise busy or touch HI/LO.
    issue(3'b010, 32'd10, 32'd2);
    for (int i = 0; i < 12; i++) begin
      chk("nodiv_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
    end
    chk("nodiv_hi", hi, 32'h12345678);
    chk("nodiv_lo", lo, 32'h12345678);
    issue(3'b011, 32'd10, 32'd3);
    chk("nodivu_busy", {31'd0, busy}, 32'd0);
    chk("nodivu_lo", lo, 32'h12345678);
`endif

    // Asynchronous reset in the middle of a MULT aborts it.
    issue(3'b000, 32'd3, 32'd4);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_abort_busy", {31'd0, busy}, 32'd0);
    end
    chk("post_abort_hi", hi, 32'd0);
    chk("post_abort_lo", lo, 32'd0);

    // Start presented together with reset release is taken at the first posedge.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    op    = 3'b000;
    a     = 32'd6;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    run_check(5, 32'h00000000, 32'h0000002A, "first_start");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, multiply latency in clock cycles (range 1..15).
REQ-002 Parameter DIV_CYCLES, default 10, divide latency in clock cycles (range 1..15).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  qualifies op for one cycle; sampled at posedge clk.
REQ-006 op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-007 a  input  32  operand A (rs value from the EX-stage register file read, RData1_E).
REQ-008 b  input  32  operand B (rt value, RData2_E).
REQ-009 busy  output  1  operation in flight; the hazard unit stalls the ID/EX register on any MD instruction while busy or start is high.
REQ-010 hi  output  32  HI register.
REQ-011 lo  output  32  LO register.

Function
REQ-012 The block SHALL be a two-state FSM: IDLE and RUN, with a 4-bit down-counter cnt.
REQ-013 In IDLE, start=1 with op MULT/MULTU/DIV/DIVU SHALL latch a, b and op, load cnt with MULT_CYCLES or DIV_CYCLES, and enter RUN at the same edge.
REQ-014 busy SHALL be high exactly while in RUN, i.e. for N cycles after the start edge (N = the selected latency).
REQ-015 In RUN, cnt SHALL decrement each cycle; at the edge where cnt reaches 0, hi/lo SHALL load the result and the FSM SHALL return to IDLE, with busy low in the same cycle the new hi/lo are visible.
REQ-016 MULT SHALL compute the signed 32x32->64 product; MULTU the unsigned product; {hi,lo} = product.
REQ-017 DIV SHALL compute a signed quotient truncated toward zero; lo = quotient, hi = remainder carrying the dividend's sign.
REQ-018 DIVU SHALL compute the unsigned quotient and remainder.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-020 For DIV/DIVU with b=0, the block SHALL run the full DIV_CYCLES with busy high, then leave hi/lo unchanged.
REQ-021 MTHI/MTLO with start=1 in IDLE SHALL write a into hi/lo at that edge, with no busy assertion.
REQ-022 start=1 while in RUN SHALL be ignored for every op, including MTHI/MTLO.
REQ-023 Reserved ops SHALL be no-ops.
REQ-024 Operand changes on a/b during RUN SHALL NOT affect the result.
REQ-025 hi/lo SHALL hold their value in all cycles not covered by REQ-015/021.

Reset
REQ-026 rst=0 SHALL immediately force state=IDLE, cnt=0, busy=0, hi=0, lo=0, and clear the latched operands, independent of clk.
REQ-027 Reset asserted during RUN SHALL abort the operation; no result SHALL be written after release.
REQ-028 The first start SHALL be accepted on the first posedge after rst returns high.

Configuration
REQ-029 With macro MD_UNIT_DIV_EN defined, DIV/DIVU SHALL behave per REQ-017..020.
REQ-030 With MD_UNIT_DIV_EN undefined, no divider logic SHALL be built, and DIV/DIVU SHALL be no-ops: busy stays low and hi/lo are unchanged.

Verification
REQ-031 Reset, then MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
REQ-032 MULTU a=0xFFFFFFFF, b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
REQ-033 DIV a=0xFFFFFFF9 (-7), b=2 -> busy high 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Separately, DIVU a=7, b=0 with hi=lo=0x12345678 preloaded via MTHI/MTLO -> both still 0x12345678 after 10 cycles.
REQ-034 MTHI a=0xDEADBEEF issued during a running MULT -> ignored; final hi equals the MULT result.
REQ-035 Start MULT, assert rst=0 at cycle 3 asynchronously -> busy=0 and hi=lo=0 immediately; after release hi/lo stay 0 and busy stays 0.
REQ-036 Build without MD_UNIT_DIV_EN: DIV a=10, b=2 -> busy never rises; hi/lo unchanged.
